// File: rtl/mem_port_arbiter.sv
// Round-robin N-port arbiter in front of a single-ported word memory.
// One transaction in flight; per-port ready pulse with rdata/err.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS*DATA_W-1:0]   req_rdata,
  output logic [NUM_PORTS-1:0]          req_err,
  output logic                          busy,
  output logic [31:0]                   conflict_cnt
);

  localparam int BW = DATA_W / 8;
  localparam int LSB = $clog2(BW);
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gnt;
  logic [PW-1:0]     gnt_q;
  logic              any;
  int                idx;
  logic [ADDR_W-1:0] g_addr;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] widx;
  logic              g_write;
  logic [BW-1:0]     g_strb;
  logic [DATA_W-1:0] g_wdata;
  logic              in_rng;
  logic              grant;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;
  logic [1:0]        wcnt;
  logic [3:0]        nvalid;
  logic [32:0]       csum;

  // Rotating priority search starting at the pointer
  always_comb begin
    any = 1'b0;
    gnt = '0;
    idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        gnt = PW'(idx);
      end
    end
  end

  assign grant   = (state == IDLE) && any;
  assign g_addr  = req_addr[int'(gnt)*ADDR_W +: ADDR_W];
  assign g_write = req_write[gnt];
  assign g_strb  = req_wstrb[int'(gnt)*BW +: BW];
  assign g_wdata = req_wdata[int'(gnt)*DATA_W +: DATA_W];
  assign off     = g_addr - BASE_ADDR;
  assign widx    = off >> LSB;
  assign in_rng  = (g_addr >= BASE_ADDR) &&
                   (widx < ADDR_W'(DEPTH_WORDS));

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (any) begin
          if (!g_write && in_rng && (READ_LATENCY > 1))
            state_nx = WAIT;
          else
            state_nx = RESP;
        end
      end
      WAIT: if (wcnt == '0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Grant capture, read data register and wait countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      gnt_q <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
      wcnt  <= '0;
    end else if (grant) begin
      gnt_q <= gnt;
      ptr   <= (int'(gnt) == NUM_PORTS-1) ? '0 : gnt + 1'b1;
      err_q <= !in_rng;
      wcnt  <= 2'((READ_LATENCY > 1) ? READ_LATENCY-2 : 0);
      rd_q  <= (in_rng && !g_write) ? mem[widx[IW-1:0]] : '0;
    end else if (state == WAIT && wcnt != '0) begin
      wcnt <= wcnt - 1'b1;
    end
  end

  // Byte-lane memory write on the grant edge; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && grant && g_write && in_rng) begin
      for (int b = 0; b < BW; b++)
        if (g_strb[b])
          mem[widx[IW-1:0]][b*8 +: 8] <= g_wdata[b*8 +: 8];
    end
  end

  // Waiting requesters this cycle, minus the one being granted
  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      nvalid = nvalid + 4'(req_valid[i]);
    csum = {1'b0, conflict_cnt} + 33'(nvalid) - 33'(grant);
  end

  // Saturating contention counter
  always_ff @(posedge clk) begin
    if (reset)        conflict_cnt <= '0;
    else if (csum[32]) conflict_cnt <= '1;
    else              conflict_cnt <= csum[31:0];
  end

  // Response steering to the granted port only
  always_comb begin
    req_ready = '0;
    req_rdata = '0;
    req_err   = '0;
    if (state == RESP) begin
      req_ready[gnt_q] = 1'b1;
      req_err[gnt_q]   = err_q;
      req_rdata[int'(gnt_q)*DATA_W +: DATA_W] = rd_q;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Parametrised N-port arbiter with its own on-chip word memory. It lets the CPU data port and one or more PCPI accelerator memory ports share a single-ported memory array. It replaces the fixed two-port memory model: port count, depth, base address and read latency are all configurable. It adds round-robin fairness, out-of-range error reporting and a contention counter.

Parameters:
NUM_PORTS, 2, number of requester channels (1..8)
ADDR_W, 32, byte-address width
DATA_W, 32, word width (multiple of 8)
DEPTH_WORDS, 4096, words of backing memory
BASE_ADDR, 32'h0001_0000, byte address of word 0
READ_LATENCY, 1, cycles from grant to read response (1..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
req_valid  in  NUM_PORTS  per-port request; held high until req_ready
req_write  in  NUM_PORTS  1 = write, 0 = read
req_wstrb  in  NUM_PORTS*DATA_W/8  byte enables for writes; port p occupies slice p
req_addr  in  NUM_PORTS*ADDR_W  byte address per port
req_wdata  in  NUM_PORTS*DATA_W  write data per port
req_ready  out  NUM_PORTS  one-cycle completion pulse per port
req_rdata  out  NUM_PORTS*DATA_W  read data, valid while that port's req_ready=1
req_err  out  NUM_PORTS  out-of-range flag, valid with req_ready
busy  out  1  transaction in flight (state != IDLE)
conflict_cnt  out  32  saturating count of cycles in which a port has valid high but no grant

Behaviour:
- Reset values: req_ready=0, req_rdata=0, req_err=0, busy=0, conflict_cnt=0, FSM=IDLE, round-robin pointer=0 (port 0 has highest priority).
- Memory contents are not cleared by reset.
- One transaction is in flight at a time. FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first requesting port at or after the pointer, wrapping modulo NUM_PORTS.
  - Latch the grant index, write flag, address, strobes and wdata on that edge.
  - Advance the pointer to grant+1 (wraps to 0).
- Address check: offset = addr - BASE_ADDR; word index = offset >> log2(DATA_W/8).
  - In range when addr >= BASE_ADDR and word index < DEPTH_WORDS.
  - Low address bits are ignored.
- Write, in range: memory is updated on the grant edge, per byte lane where the strobe is 1. Next cycle is RESP.
- Write with wstrb all 0: no memory change, normal response, err=0.
- Read, in range: WAIT for READ_LATENCY-1 cycles (skip WAIT when READ_LATENCY=1), then RESP with the registered data.
  - Read latency is READ_LATENCY cycles from the grant edge.
- Out of range, read or write: no memory access; go to RESP next cycle with err=1 and rdata=0.
- RESP:
  - Only the granted port's req_ready is 1, for exactly one cycle, with its req_rdata and req_err.
  - All other ports' rdata and err are 0.
  - Next state is IDLE.
  - The earliest next grant is the cycle after RESP; requesters drop valid on the ready edge.
- Write response latency: 1 cycle after grant. Back-to-back throughput is one write per 2 cycles.
- Request fields are captured only at grant. Changing or dropping valid after grant does not cancel the transaction; ready still pulses.
- conflict_cnt increments by the number of ports with valid=1 that are not being granted this cycle.
  - This includes all valid ports while in WAIT or RESP.
  - Saturates at 32'hFFFF_FFFF.
- Reset mid-transaction:
  - The FSM aborts to IDLE and no ready pulse is issued.
  - A write already committed on its grant edge stays in memory; writes are atomic.
- Simultaneous requests from all ports are served strictly in rotating order. No port waits more than NUM_PORTS-1 grants.

Test Plan:
- Single port 0 writes 32'hDEADBEEF to 0x00010008 with wstrb=4'hF, then reads the same address -> write ready at T+1, read ready at T+1 with rdata=32'hDEADBEEF, err=0.
- Partial write with wstrb=4'b0010, wdata=32'h0000AB00, onto a word holding 32'h11223344 -> subsequent read returns 32'h1122AB44.
- NUM_PORTS=2, both valid continuously with pointer=0 -> grants alternate 0,1,0,1; each ready is 1 cycle wide; conflict_cnt rises by 1 in IDLE and by 2 in RESP cycles, as defined.
- Read of 0x0000FFFC and of BASE_ADDR+4*DEPTH_WORDS -> ready with err=1, rdata=0; memory unchanged.
- READ_LATENCY=3, read at grant cycle T -> ready exactly at T+3; busy high for cycles T+1..T+3.
- Assert reset in the WAIT cycle of a read -> no req_ready, busy=0 next cycle; a prior write to 0x00010010 of 32'h5A5A5A5A still reads back correctly.
